// File: rtl/l1_wb_pkg.sv
// l1_wb_pkg: shared state type, default Wishbone widths and counter sizing for l1_wb_arb.
package l1_wb_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} arb_state_t;
    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_BE_W = 4;
    function automatic int outst_w(input int max_outst);
        return $clog2(max_outst + 1);
    endfunction
endpackage

// File: rtl/l1_wb_arb_rr.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr, plus the pointer that follows it.
module rr_arbiter #(
    parameter int N = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] nxt_ptr
);
    int idx;
    logic found;
    always_comb begin
        gnt = '0;
        nxt_ptr = ptr;
        idx = 0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx] && !found) begin
                found = 1'b1;
                gnt[idx] = 1'b1;
                nxt_ptr = PW'((idx + 1) % N);
            end
        end
    end
endmodule

// File: rtl/l1_wb_arb.sv
// l1_wb_arb: round-robin Wishbone B4 pipelined arbiter holding grant for a whole cycle and draining in-flight acks.
// Optional watchdog built only when L1_WB_ARB_TIMEOUT_EN is defined.
module l1_wb_arb import l1_wb_pkg::*; #(
    parameter int N_MST = 2,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W,
    parameter int BE_W = WB_BE_W,
    parameter int MAX_OUTST = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [N_MST-1:0]         m_cyc_i,
    input  logic [N_MST-1:0]         m_stb_i,
    input  logic [N_MST-1:0]         m_we_i,
    input  logic [N_MST*ADDR_W-1:0]  m_adr_i,
    input  logic [N_MST*DATA_W-1:0]  m_dat_i,
    input  logic [N_MST*BE_W-1:0]    m_sel_i,
    output logic [N_MST-1:0]         m_stall_o,
    output logic [N_MST-1:0]         m_ack_o,
    output logic [N_MST-1:0]         m_err_o,
    output logic [DATA_W-1:0]        m_dat_o,
    output logic                     s_cyc_o,
    output logic                     s_stb_o,
    output logic                     s_we_o,
    output logic [ADDR_W-1:0]        s_adr_o,
    output logic [DATA_W-1:0]        s_dat_o,
    output logic [BE_W-1:0]          s_sel_o,
    input  logic                     s_stall_i,
    input  logic                     s_ack_i,
    input  logic                     s_err_i,
    input  logic [DATA_W-1:0]        s_dat_i,
    output logic                     timeout_o
);
    localparam int PW = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int OW = outst_w(MAX_OUTST);

    if (N_MST < 2 || N_MST > 8 || MAX_OUTST < 1 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("l1_wb_arb: unsupported parameter set");
    end

    arb_state_t state, state_nxt;
    logic [N_MST-1:0] gnt, arb_gnt;
    logic [PW-1:0] ptr, pend, arb_ptr;
    logic [OW-1:0] outst, outst_nxt;
    logic cyc_g, stb_g, full, acc, resp, tmo, rel;

    rr_arbiter #(.N(N_MST), .PW(PW)) u_rr (
        .req(m_cyc_i), .ptr(ptr), .gnt(arb_gnt), .nxt_ptr(arb_ptr)
    );

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        for (int i = 0; i < N_MST; i++) begin
            s_adr_o = s_adr_o | ({ADDR_W{gnt[i]}} & m_adr_i[i*ADDR_W +: ADDR_W]);
            s_dat_o = s_dat_o | ({DATA_W{gnt[i]}} & m_dat_i[i*DATA_W +: DATA_W]);
            s_sel_o = s_sel_o | ({BE_W{gnt[i]}} & m_sel_i[i*BE_W +: BE_W]);
        end
    end

    assign cyc_g = |(m_cyc_i & gnt);
    assign stb_g = |(m_stb_i & gnt);
    assign s_we_o = |(m_we_i & gnt);
    assign full = outst == OW'(MAX_OUTST);
    assign s_cyc_o = state != IDLE;
    assign s_stb_o = (state == GRANT) && cyc_g && stb_g && !full;
    assign acc = s_stb_o && !s_stall_i;
    // Responses with nothing outstanding are stray and neither counted nor forwarded.
    assign resp = (s_ack_i || s_err_i) && outst != '0;
    assign outst_nxt = outst + OW'(acc) - OW'(resp);
    assign m_stall_o = (state == GRANT) ? (~gnt | {N_MST{s_stall_i | full}}) : '1;
    assign m_ack_o = (state == GRANT && s_ack_i && outst != '0) ? gnt : '0;
    assign m_err_o = ((state == GRANT && s_err_i && outst != '0) || tmo) ? gnt : '0;
    assign m_dat_o = s_dat_i;

    always_comb begin
        state_nxt = state;
        rel = 1'b0;
        case (state)
            IDLE: state_nxt = |m_cyc_i ? GRANT : IDLE;
            GRANT: if (!cyc_g) begin
                state_nxt = (outst_nxt == '0) ? IDLE : DRAIN;
                rel = outst_nxt == '0;
            end
            DRAIN: if (outst_nxt == '0) begin
                state_nxt = IDLE;
                rel = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        if (tmo) begin
            state_nxt = IDLE;
            rel = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            gnt <= '0;
            ptr <= '0;
            pend <= '0;
            outst <= '0;
        end else begin
            state <= state_nxt;
            outst <= tmo ? '0 : outst_nxt;
            if (state == IDLE && state_nxt == GRANT) begin
                gnt <= arb_gnt;
                pend <= arb_ptr;
            end
            if (rel) begin
                gnt <= '0;
                ptr <= pend;
            end
        end
    end

`ifdef L1_WB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wd;
    logic to_flag;
    assign tmo = outst != '0 && !resp && wd == TW'(TIMEOUT_CYC - 1);
    assign timeout_o = to_flag;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wd <= '0;
            to_flag <= 1'b0;
        end else begin
            wd <= (outst != '0 && !resp && !tmo) ? wd + 1'b1 : '0;
            to_flag <= to_flag | tmo;
        end
    end
`else
    assign tmo = 1'b0;
    assign timeout_o = 1'b0;
`endif
endmodule

// File: doc/l1_wb_arb.md
Name: l1_wb_arb

Overview:
- Round-robin arbiter that shares one Wishbone B4 pipelined slave port among N cache memory-access masters (per-core L1 MAUs, DMA).
- Grant is held for a master's whole cycle (wb_cyc high).
- Counts outstanding strobes against acks, so a cycle is never handed off while responses are still in flight.
- Sits between the L1 MAU instances and the system bus / memory controller.

Parameters:
- N_MST, 2, number of masters (2..8)
- ADDR_W, 32, Wishbone address width
- DATA_W, 32, Wishbone data width
- BE_W, 4, select width (DATA_W/8)
- MAX_OUTST, 8, max accepted-but-unacked strobes per cycle
- TIMEOUT_CYC, 1024, watchdog limit (only with optional feature)

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- m_cyc_i  in  N_MST  per-master cycle
- m_stb_i  in  N_MST  per-master strobe
- m_we_i  in  N_MST  per-master write enable
- m_adr_i  in  N_MST*ADDR_W  packed addresses, master 0 in LSBs
- m_dat_i  in  N_MST*DATA_W  packed write data
- m_sel_i  in  N_MST*BE_W  packed byte selects
- m_stall_o  out  N_MST  per-master stall
- m_ack_o  out  N_MST  per-master ack
- m_err_o  out  N_MST  per-master error
- m_dat_o  out  DATA_W  read data, broadcast; valid only with own ack
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side controls
- s_adr_o  out  ADDR_W  slave address
- s_dat_o  out  DATA_W  slave write data
- s_sel_o  out  BE_W  slave byte selects
- s_stall_i, s_ack_i, s_err_i  in  1 each  slave responses
- s_dat_i  in  DATA_W  slave read data
- timeout_o  out  1  sticky watchdog flag (optional feature only, else tied 0)

Behaviour:
- Reset (sync, active-high):
  - Clears: state=IDLE, grant=0, rr pointer=0, outst=0.
  - Outputs in that cycle: s_cyc_o=0, s_stb_o=0, m_stall_o=all 1, m_ack_o=0, m_err_o=0.
  - Reset mid-cycle abandons in-flight acks; nothing is replayed.
- States:
  - IDLE: no grant; all m_stall_o=1; s_cyc_o=0.
    - If any m_cyc_i is set, pick the first requester at or after the rr pointer (wrapping), register the one-hot grant and go to GRANT.
    - No grant is issued in the same cycle as the request: one cycle of arbitration latency.
  - GRANT: slave bus is a combinational mux of the granted master; s_cyc_o=1.
    - s_stb_o = m_stb_i[g] & (outst<MAX_OUTST).
    - m_stall_o[g] = s_stall_i | (outst==MAX_OUTST); all other stalls = 1.
    - s_ack_i/s_err_i route to the granted master only.
    - When m_cyc_i[g] falls: if outst==0 (or decrements to 0 this cycle), go to IDLE and set the rr pointer to g+1 mod N_MST; otherwise go to DRAIN.
  - DRAIN: s_cyc_o=1, s_stb_o=0.
    - Acks/errs are absorbed and not forwarded.
    - When outst reaches 0, go to IDLE and advance the pointer as above.
- outst counter:
  - +1 on s_stb_o & ~s_stall_i.
  - -1 on s_ack_i | s_err_i.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTST; a response with outst==0 is ignored, and the counter does not underflow.
- s_err_i counts as the terminating response for that strobe, same as ack.
- A master dropping m_cyc_i while stalled loses its pending strobe. That is legal, and it is not counted.
- Fairness: each master is served at most once per rotation while others are waiting.

Optional Feature:
- Macro: L1_WB_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles with outst>0 and no response, and resets on each response.
  - When it reaches TIMEOUT_CYC: pulse m_err_o[g] for one cycle, clear outst, set timeout_o sticky (cleared only by reset), and go to IDLE.
- Undefined: no watchdog logic is built and timeout_o is tied to 0.

Decomposition:
- Package l1_wb_pkg holds:
  - The arb_state_t enum (IDLE, GRANT, DRAIN).
  - Default width constants: WB_ADDR_W, WB_DATA_W, WB_BE_W.
  - The clog2-derived width of the outstanding counter.
- Sub-module rr_arbiter (N_MST request vector + pointer -> one-hot grant + next pointer) is natural; it is purely combinational, and the pointer register lives in l1_wb_arb.

Test Plan:
- Single master, 4-beat burst, s_stall_i=0, 1-cycle ack latency: s_cyc_o rises 1 cycle after m_cyc_i[0]; 4 acks reach master 0 only; grant releases once cyc drops with outst=0.
- Masters 0 and 1 request in the same cycle, each issuing 2 cycles back-to-back: grant order 0,1,0,1; m_stall_o[1]=1 throughout master 0's cycles.
- MAX_OUTST=8, 10 strobes issued, slave acks withheld: s_stb_o gated after 8 accepts and m_stall_o[g]=1; first ack releases exactly one more strobe.
- Master drops cyc with outst=3: state goes to DRAIN, 3 acks are absorbed (m_ack_o stays 0), then IDLE; a waiting master is granted only after that.
- Reset asserted in GRANT with outst=5: next cycle s_cyc_o=0, all m_stall_o=1, outst=0; late s_ack_i is ignored.
- With L1_WB_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, one strobe never acked: m_err_o[g] pulses 16 cycles after the last activity, timeout_o=1 and stays set, and the arbiter returns to IDLE.
